// File: rtl/dice_roll_ctrl.sv
// rtl/dice_roll_ctrl.sv - dice roll sequencer: press detect, spin, decelerate, show
//
// Purpose: turns the debounced roll button into one dice roll. The face spins
// at a fixed rate while the button is held. After release it slows through
// SLOW_STEPS updates, each interval twice the previous one. The last face is then
// latched and shown. All randomness comes from a free-running 16-bit LFSR.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   btn_db       debounced button level, 1 = pressed
//   face         current face, always 1..6
//   rolling      high while spinning or slowing down
//   result_valid high while the final face is shown
//   done         one-cycle pulse on the first SHOW cycle
//   roll_count   completed rolls, wraps 255 -> 0
module dice_roll_ctrl #(
  parameter int unsigned SPIN_TICKS = 250000,
  parameter int unsigned SLOW_STEPS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_db,
  output logic [2:0] face,
  output logic       rolling,
  output logic       result_valid,
  output logic       done,
  output logic [7:0] roll_count
);

  typedef enum logic [1:0] {IDLE, SPIN, SLOW, SHOW} state_e;

  localparam logic [31:0] SPIN_LAST = 32'(SPIN_TICKS - 1);
  localparam logic [4:0]  STEP_LAST = 5'(SLOW_STEPS - 1);

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [4:0]  step_q, step_d;
  logic [2:0]  face_q, face_d;
  logic        done_q, done_d;
  logic [7:0]  roll_count_q, roll_count_d;
  logic [15:0] lfsr_q;
  logic        btn_prev_q;
  logic        rise_q, fall_q;
  logic [2:0]  face_next;
  logic [31:0] slow_interval;

  // Button edges are registered, so the FSM acts one edge after the edge
  // is sampled. btn_prev resets to 1, so a press held through reset is not a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q     <= 16'hACE1;
      btn_prev_q <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      lfsr_q     <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      btn_prev_q <= btn_db;
      rise_q     <= btn_db & ~btn_prev_q;
      fall_q     <= ~btn_db & btn_prev_q;
    end
  end

  // Candidate face for an update. LFSR codes 0 and 7 are not valid faces, so
  // those codes step the current face forward instead.
  always_comb begin
    if (lfsr_q[2:0] >= 3'd1 && lfsr_q[2:0] <= 3'd6) begin
      face_next = lfsr_q[2:0];
    end else if (face_q == 3'd6) begin
      face_next = 3'd1;
    end else begin
      face_next = face_q + 3'd1;
    end
  end

  // Each slow step doubles the interval: SPIN_TICKS*2, *4, *8, ...
  assign slow_interval = 32'(SPIN_TICKS) << (step_q + 5'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      step_q       <= '0;
      face_q       <= 3'd1;
      done_q       <= 1'b0;
      roll_count_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      step_q       <= step_d;
      face_q       <= face_d;
      done_q       <= done_d;
      roll_count_q <= roll_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    step_d       = step_q;
    face_d       = face_q;
    done_d       = 1'b0;
    roll_count_d = roll_count_q;
    case (state_q)
      IDLE, SHOW: begin
        if (rise_q) begin
          state_d = SPIN;
          timer_d = '0;
        end
      end
      SPIN: begin
        // Release wins over a coincident timer expiry; no update that cycle.
        if (fall_q) begin
          state_d = SLOW;
          step_d  = '0;
          timer_d = '0;
        end else if (timer_q == SPIN_LAST) begin
          face_d  = face_next;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      SLOW: begin
        // Button activity is deliberately ignored here.
        if (timer_q == slow_interval - 32'd1) begin
          face_d  = face_next;
          timer_d = '0;
          if (step_q == STEP_LAST) begin
            state_d      = SHOW;
            done_d       = 1'b1;
            roll_count_d = roll_count_q + 8'd1;
          end else begin
            step_d = step_q + 5'd1;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign face         = face_q;
  assign done         = done_q;
  assign roll_count   = roll_count_q;
  assign rolling      = (state_q == SPIN) || (state_q == SLOW);
  assign result_valid = (state_q == SHOW);

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// tb/tb_dice_roll_ctrl.sv - self-checking bench for dice_roll_ctrl
module tb_dice_roll_ctrl;

  localparam int SPIN_T     = 4;
  localparam int SLOW_N     = 3;
  localparam int SLOW_TOTAL = SPIN_T * ((1 << (SLOW_N + 1)) - 2);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_db;
  logic [2:0] face;
  logic       rolling;
  logic       result_valid;
  logic       done;
  logic [7:0] roll_count;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  logic [15:0] m_lfsr;
  logic [2:0]  m_face;
  logic        exp_rolling, exp_valid, exp_done;
  logic [7:0]  exp_count;
  logic [7:0]  sb_q[$];

  dice_roll_ctrl #(.SPIN_TICKS(SPIN_T), .SLOW_STEPS(SLOW_N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_db       (btn_db),
    .face         (face),
    .rolling      (rolling),
    .result_valid (result_valid),
    .done         (done),
    .roll_count   (roll_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [2:0] next_face(input logic [2:0] f, input logic [2:0] c);
    if (c >= 3'd1 && c <= 3'd6) return c;
    if (f == 3'd6) return 3'd1;
    return f + 3'd1;
  endfunction

  // True on the SLOW offsets where an update lands: 8, 24, 56 for 4/3.
  function automatic bit slow_upd(input int t);
    int acc = 0;
    for (int s = 0; s < SLOW_N; s++) begin
      acc += SPIN_T << (s + 1);
      if (t == acc) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock edge. Expectations for after the edge are set by the caller.
  task automatic tick(input bit upd);
    logic [15:0] l;
    l = m_lfsr;
    @(posedge clk);
    if (upd) m_face = next_face(m_face, l[2:0]);
    m_lfsr = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    #1;
    check("face", 32'(face), 32'(m_face));
    check("rolling", 32'(rolling), 32'(exp_rolling));
    check("result_valid", 32'(result_valid), 32'(exp_valid));
    check("done", 32'(done), 32'(exp_done));
    check("roll_count", 32'(roll_count), 32'(exp_count));
  endtask

  task automatic model_reset();
    m_lfsr      = 16'hACE1;
    m_face      = 3'd1;
    exp_rolling = 1'b0;
    exp_valid   = 1'b0;
    exp_done    = 1'b0;
    exp_count   = 8'd0;
  endtask

  // One roll: press for 'hold' cycles, optional button pulses during SLOW,
  // optional asynchronous reset at SLOW offset rst_at (0 = none).
  task automatic roll(input int hold, input bit toggle, input int rst_at);
    btn_db = 1'b1;
    sb_q.push_back(exp_count + 8'd1);
    exp_done = 1'b0;
    tick(1'b0);                          // rise sampled; still not rolling
    exp_rolling = 1'b1;
    exp_valid   = 1'b0;
    for (int j = 1; j <= hold + 1; j++) begin
      if (j == hold) btn_db = 1'b0;
      tick(j > 1 && ((j - 1) % SPIN_T) == 0 && j <= hold);
    end
    for (int t = 1; t <= SLOW_TOTAL; t++) begin
      if (t == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_face", 32'(face), 32'd1);
        check("rst_rolling", 32'(rolling), 32'd0);
        check("rst_count", 32'(roll_count), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        model_reset();
        sb_q.delete();
        btn_db = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_lfsr = 16'hACE1;
        return;
      end
      if (toggle && (t == 5 || t == 30)) btn_db = 1'b1;
      if (toggle && (t == 6 || t == 31)) btn_db = 1'b0;
      if (t == SLOW_TOTAL) begin
        exp_rolling = 1'b0;
        exp_valid   = 1'b1;
        exp_done    = 1'b1;
        exp_count   = exp_count + 8'd1;
      end
      tick(slow_upd(t));
    end
    exp_done = 1'b0;
    tick(1'b0);
  endtask

  // Scoreboard side: every done pops the roll_count pushed at its press.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("face_range", 32'(face >= 3'd1 && face <= 3'd6), 32'd1);
      if (done === 1'b1) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          check("done_unexpected", 32'(done), 32'd0);
        end else begin
          logic [7:0] e;
          e = sb_q.pop_front();
          check("sb_count", 32'(roll_count), 32'(e));
        end
      end
    end
  end

  initial begin
    int d0;
    rst_n  = 1'b0;
    btn_db = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_face", 32'(face), 32'd1);
    check("reset_rolling", 32'(rolling), 32'd0);
    check("reset_valid", 32'(result_valid), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_count", 32'(roll_count), 32'd0);
    rst_n = 1'b1;

    // Button held through reset release must not start a roll.
    repeat (20) tick(1'b0);
    btn_db = 1'b0;
    tick(1'b0);

    // 13-cycle press: 3 spin updates, slow updates at 8/24/56.
    roll(13, 1'b0, 0);
    // Button pulses during SLOW are ignored.
    roll(5, 1'b1, 0);
    // Reset mid-SLOW abandons the roll.
    roll(6, 1'b0, 10);
    repeat (20) tick(1'b0);

    // 256 short rolls: roll_count wraps to 0.
    d0 = done_cnt;
    for (int r = 0; r < 256; r++) roll(2, 1'b0, 0);
    check("done_total_256", 32'(done_cnt - d0), 32'd256);
    check("count_wrap", 32'(roll_count), 32'd0);

    // Short press from SHOW: no spin update, full slow-down.
    roll(2, 1'b0, 0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dice_roll_ctrl.md
# dice_roll_ctrl

- Sequences one dice roll from the debounced roll button.
- Detects the press edge, spins the displayed face while the button is held, then decelerates through a fixed number of slowing steps after release.
- Latches the final face, flags it valid and pulses `done`.
- Sits between the debouncer output and the seven-segment/LED display driver; all randomness comes from an internal free-running LFSR.

## Interface
- SPIN_TICKS, 250000 — clk cycles between face updates while spinning; must be ≥ 2.
- SLOW_STEPS, 6 — number of decelerating face updates after release; 1..16.
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- btn_db  input  1  debounced button level, 1 = pressed, synchronous to clk.
- face  output  3  current face value, always in 1..6.
- rolling  output  1  high in SPIN and SLOW.
- result_valid  output  1  high in SHOW.
- done  output  1  one-cycle pulse on the first SHOW cycle of each roll.
- roll_count  output  8  completed rolls, wraps 255→0.

## Operation
- Reset values:
  - state = IDLE, face = 1, rolling = 0, result_valid = 0, done = 0, roll_count = 0.
  - lfsr = 16'hACE1; btn_prev = 1, so a button held through reset release does not start a roll.
- LFSR:
  - 16-bit, advances every clk in every state: lfsr ← {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- Face update rule:
  - c = lfsr[2:0].
  - If 1 ≤ c ≤ 6, face ← c; otherwise face ← face+1, with 6 wrapping to 1.
- Rise = btn_db & ~btn_prev; fall = ~btn_db & btn_prev. btn_prev ← btn_db every cycle.
- IDLE:
  - face holds; on rise → SPIN, timer ← 0.
- SPIN:
  - interval = SPIN_TICKS; timer counts up.
  - When timer == interval−1: apply face update, timer ← 0.
  - On fall → SLOW with step ← 0, timer ← 0. A fall takes priority over a coincident timer expiry (no update that cycle).
- SLOW:
  - interval = SPIN_TICKS << (step+1).
  - At timer == interval−1: apply face update, timer ← 0, step ← step+1.
  - When the update with step == SLOW_STEPS−1 occurs → SHOW on the same edge.
  - Presses and releases during SLOW are ignored: no restart, no queued roll.
- SHOW:
  - face frozen; result_valid = 1; roll_count increments once on entry.
  - done = 1 for the first SHOW cycle only.
  - On rise → SPIN, same as IDLE.
- The timer is 32 bits wide. SPIN_TICKS << SLOW_STEPS must fit in 32 bits; this is a parameter legality rule, with no runtime check.
- Outputs are registered. rolling/result_valid are decoded from the registered state.

## Timing
- A rise sampled at edge N puts the block in SPIN after edge N+1, and rolling rises in that cycle.
- First SPIN face update: SPIN_TICKS cycles after SPIN entry, then every SPIN_TICKS cycles.
- A fall sampled at edge M puts the block in SLOW after edge M+1.
- SLOW duration from entry to the SHOW entry edge: SPIN_TICKS·(2^(SLOW_STEPS+1) − 2) cycles.
- done asserts in the same cycle result_valid first rises, and deasserts after exactly one cycle.
- Press held shorter than SPIN_TICKS: zero SPIN updates, and SLOW still runs all SLOW_STEPS updates.
- rst_n low at any time, including mid-SPIN or mid-SLOW: all outputs return to their reset values asynchronously; the roll is abandoned and roll_count clears.

## Test plan
(Bench parameters: SPIN_TICKS = 4, SLOW_STEPS = 3; slow intervals are 8, 16, 32 cycles.)
- Reset with btn_db held 1, release rst_n and hold btn_db 1 for 20 cycles → stays IDLE, face = 1, rolling = 0. Then drop and raise btn_db → SPIN two edges after the rise.
- Press for 13 cycles then release → exactly 3 SPIN updates at 4-cycle spacing. SLOW updates at offsets 8, 24, 56 cycles after SLOW entry. SHOW entered with result_valid = 1, single-cycle done, roll_count = 1.
- Toggle btn_db during SLOW (pulses at SLOW+5 and SLOW+30) → update offsets unchanged; exactly one done; state returns to SHOW.
- Assert rst_n low at SLOW+10 → face = 1, rolling = 0, roll_count = 0 immediately. After release, no roll until a new rise.
- Run 256 complete rolls → roll_count wraps to 0; face is in 1..6 on every cycle (assertion); done count = 256.
- Press for 2 cycles only → no SPIN update; SLOW runs exactly 3 updates; SHOW reached 56 cycles after SLOW entry.
